// File: rtl/soc_pkg.sv
// Shared SoC datapath types and helpers.
// Provides the pipe_adder flag bundle, its stage limit and the slice-width helper.
package soc_pkg;

  typedef struct packed {
    logic cout;
    logic ovf;
  } pipe_adder_flags_t;

  localparam int PIPE_ADDER_MAX_STAGES = 16;

  // Returns 0 when the width cannot be split evenly, which callers treat as illegal.
  function automatic int chunk_width(input int width, input int stages);
    if (stages < 1) return 0;
    if ((width % stages) != 0) return 0;
    return width / stages;
  endfunction

endpackage

// File: rtl/pipe_adder_slice.sv
// Combinational carry-chain slice for pipe_adder: a WIDTH-bit ripple of full adders,
// each full adder built from two halfadder cells and an OR.
module halfadder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module adder_slice #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Per-bit carries live in each bit's scope so the chain is not one self-dependent vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic ci;
    logic co;
    logic s1;
    logic c1;
    logic c2;

    if (i == 0) begin : g_ci
      assign ci = cin;
    end else begin : g_ci
      assign ci = g_bit[i-1].co;
    end

    halfadder u_ha0 (.a(a[i]), .b(b[i]), .sum(s1),     .carry(c1));
    halfadder u_ha1 (.a(s1),   .b(ci),   .sum(sum[i]), .carry(c2));

    assign co = c1 | c2;
  end

  assign cout = g_bit[WIDTH-1].co;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder: STAGES registered carry-chain slices behind a valid/ready stream.
// Define PIPE_ADDER_SAT_EN to add the sat_mode input and saturating sum output.
module pipe_adder
  import soc_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPE_ADDER_SAT_EN
  input  logic             sat_mode,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int          CHUNK = chunk_width(WIDTH, STAGES);
  localparam int unsigned LAST  = STAGES - 1;

  if (WIDTH < 2 || STAGES < 1 || STAGES > PIPE_ADDER_MAX_STAGES || CHUNK == 0) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be >= 2 and divisible by STAGES (1..16)");
  end

  // Stage sources: operands right-justified (next chunk in the low bits),
  // partial sums left-justified so finished chunks shift down into place.
  logic [WIDTH-1:0] op_a   [STAGES];
  logic [WIDTH-1:0] op_b   [STAGES];
  logic [WIDTH-1:0] s_src  [STAGES];
  logic [WIDTH-1:0] s_next [STAGES];
  logic             c_src  [STAGES];
  logic             v_src  [STAGES];
  logic [CHUNK-1:0] s_chunk[STAGES];
  logic             c_chunk[STAGES];

  logic [WIDTH-1:0] a_q[STAGES];
  logic [WIDTH-1:0] b_q[STAGES];
  logic [WIDTH-1:0] s_q[STAGES];
  logic             c_q[STAGES];
  logic             v_q[STAGES];

`ifdef PIPE_ADDER_SAT_EN
  logic sat_src[STAGES];
  logic sat_q  [STAGES];
`endif

  logic              adv;
  logic [WIDTH-1:0]  final_sum;
  pipe_adder_flags_t final_flags;
  pipe_adder_flags_t flags_q;

  assign out_valid = v_q[LAST];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_src
      assign op_a[k]  = a;
      assign op_b[k]  = b;
      assign c_src[k] = cin;
      assign s_src[k] = '0;
      assign v_src[k] = in_valid;
`ifdef PIPE_ADDER_SAT_EN
      assign sat_src[k] = sat_mode;
`endif
    end else begin : g_src
      assign op_a[k]  = a_q[k-1];
      assign op_b[k]  = b_q[k-1];
      assign c_src[k] = c_q[k-1];
      assign s_src[k] = s_q[k-1];
      assign v_src[k] = v_q[k-1];
`ifdef PIPE_ADDER_SAT_EN
      assign sat_src[k] = sat_q[k-1];
`endif
    end

    adder_slice #(.WIDTH(CHUNK)) u_slice (
      .a    (op_a[k][CHUNK-1:0]),
      .b    (op_b[k][CHUNK-1:0]),
      .cin  (c_src[k]),
      .sum  (s_chunk[k]),
      .cout (c_chunk[k])
    );

    assign s_next[k] = (s_src[k] >> CHUNK) | (WIDTH'(s_chunk[k]) << (WIDTH - CHUNK));

    // Bubbles advance the valid bit only; data holds so the output never picks up X.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
`ifdef PIPE_ADDER_SAT_EN
        sat_q[k] <= 1'b0;
`endif
      end else if (adv) begin
        v_q[k] <= v_src[k];
        if (v_src[k]) begin
          c_q[k] <= c_chunk[k];
          a_q[k] <= op_a[k] >> CHUNK;
          b_q[k] <= op_b[k] >> CHUNK;
          s_q[k] <= (k == LAST) ? final_sum : s_next[k];
`ifdef PIPE_ADDER_SAT_EN
          sat_q[k] <= sat_src[k];
`endif
        end
      end
    end
  end

  always_comb begin
    final_flags.cout = c_chunk[LAST];
    final_flags.ovf  = (op_a[LAST][CHUNK-1] == op_b[LAST][CHUNK-1]) &&
                       (s_chunk[LAST][CHUNK-1] != op_a[LAST][CHUNK-1]);
    final_sum        = s_next[LAST];
`ifdef PIPE_ADDER_SAT_EN
    if (!sat_src[LAST] && final_flags.cout) begin
      final_sum = '1;
    end else if (sat_src[LAST] && final_flags.ovf) begin
      final_sum = op_a[LAST][CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (adv && v_src[LAST]) begin
      flags_q <= final_flags;
    end
  end

  assign sum  = s_q[LAST];
  assign cout = flags_q.cout;
  assign ovf  = flags_q.ovf;

endmodule
